lpddr2_responder: RTL

LPDDR2_RESPONDER -- requirements
Module: lpddr2_responder

---
 rtl/lpddr2_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lpddr2_responder.sv
// ---------------------------------------------------------------------------
// lpddr2_responder
// Bridges a simple level-held CPU read/write request port onto an
// Avalon-MM style LPDDR2 controller port. Exactly one controller
// transaction is issued per request assertion; the CPU must drop its
// request before another one is accepted.
//
// Optional feature: define LPDDR2_TIMEOUT_EN to add a read watchdog. If
// TIMEOUT_CYCLES cycles pass in RD_WAIT without readdatavalid, the read
// completes with 32'hDEADBEEF and the sticky err flag is set. Without the
// macro, RD_WAIT waits indefinitely and err is tied low.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_address         CPU word address (27b)
//   req_write_data      CPU store data (32b)
//   req_rreq, req_wreq  CPU read / write request levels
//   req_read_data       last completed read data (registered, held)
//   req_busy            transaction in flight (not IDLE, not HOLD)
//   req_done            one-cycle completion pulse
//   avl_address         controller address
//   avl_read, avl_write controller command strobes
//   avl_writedata       controller write data
//   avl_waitrequest     controller stall
//   avl_readdata        controller read data
//   avl_readdatavalid   qualifies avl_readdata
//   err                 sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module lpddr2_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [26:0] req_address,
  input  logic [31:0] req_write_data,
  input  logic        req_rreq,
  input  logic        req_wreq,
  output logic [31:0] req_read_data,
  output logic        req_busy,
  output logic        req_done,
  output logic [26:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [31:0] avl_writedata,
  input  logic        avl_waitrequest,
  input  logic [31:0] avl_readdata,
  input  logic        avl_readdatavalid,
  output logic        err
);

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

  // A zero timeout would make the watchdog compare underflow.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("lpddr2_responder: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_WAIT,
    WR_CMD,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] read_data_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic [ADDR_W-1:0] avl_address_nxt;
  logic              avl_read_nxt;
  logic              avl_write_nxt;
  logic [DATA_W-1:0] avl_writedata_nxt;

`ifdef LPDDR2_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
  logic             err_q, err_nxt;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_read_data <= '0;
      req_busy      <= 1'b0;
      req_done      <= 1'b0;
      avl_address   <= '0;
      avl_read      <= 1'b0;
      avl_write     <= 1'b0;
      avl_writedata <= '0;
`ifdef LPDDR2_TIMEOUT_EN
      wd_cnt        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      req_read_data <= read_data_nxt;
      req_busy      <= busy_nxt;
      req_done      <= done_nxt;
      avl_address   <= avl_address_nxt;
      avl_read      <= avl_read_nxt;
      avl_write     <= avl_write_nxt;
      avl_writedata <= avl_writedata_nxt;
`ifdef LPDDR2_TIMEOUT_EN
      wd_cnt        <= wd_cnt_nxt;
      err_q         <= err_nxt;
`endif
    end
  end

  // Next-state and next-output logic; strobes are set on the accepting edge
  // and cleared on the edge the controller takes the command.
  always_comb begin
    state_nxt         = state;
    read_data_nxt     = req_read_data;
    done_nxt          = 1'b0;
    avl_address_nxt   = avl_address;
    avl_read_nxt      = avl_read;
    avl_write_nxt     = avl_write;
    avl_writedata_nxt = avl_writedata;
`ifdef LPDDR2_TIMEOUT_EN
    wd_cnt_nxt        = '0;
    err_nxt           = err_q;
`endif

    case (state)
      IDLE: begin
        // Writes win when both requests are raised together.
        if (req_wreq) begin
          state_nxt         = WR_CMD;
          avl_write_nxt     = 1'b1;
          avl_read_nxt      = 1'b0;
          avl_address_nxt   = req_address;
          avl_writedata_nxt = req_write_data;
        end else if (req_rreq) begin
          state_nxt         = RD_CMD;
          avl_read_nxt      = 1'b1;
          avl_write_nxt     = 1'b0;
          avl_address_nxt   = req_address;
        end
      end

      RD_CMD: begin
        if (!avl_waitrequest) begin
          state_nxt    = RD_WAIT;
          avl_read_nxt = 1'b0;
        end
      end

      WR_CMD: begin
        if (!avl_waitrequest) begin
          state_nxt     = HOLD;
          avl_write_nxt = 1'b0;
          done_nxt      = 1'b1;
        end
      end

      RD_WAIT: begin
        if (avl_readdatavalid) begin
          state_nxt     = HOLD;
          read_data_nxt = avl_readdata;
          done_nxt      = 1'b1;
        end
`ifdef LPDDR2_TIMEOUT_EN
        // Counter holds the number of RD_WAIT cycles already spent.
        else if (wd_cnt == CNT_LAST) begin
          state_nxt     = HOLD;
          read_data_nxt = TIMEOUT_DATA;
          done_nxt      = 1'b1;
          err_nxt       = 1'b1;
        end else begin
          wd_cnt_nxt    = wd_cnt + CNT_W'(1);
        end
`endif
      end

      HOLD: begin
        // Wait for the CPU to release so one assertion means one transaction.
        if (!req_rreq && !req_wreq) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt     = IDLE;
        avl_read_nxt  = 1'b0;
        avl_write_nxt = 1'b0;
      end
    endcase
  end

  assign busy_nxt = (state_nxt != IDLE) && (state_nxt != HOLD);

`ifdef LPDDR2_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
